// File: rtl/siso_shift_register_if.sv
// Serial bit-delay line port bundle: serial data in, delayed data out and fill status.
// master drives the serial input; slave is the delay line itself.
interface siso_shift_register_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             d;
  logic             qout;
  logic             valid;
  logic [CNT_W-1:0] fill_cnt;

  modport master (
    output d,
    input  qout,
    input  valid,
    input  fill_cnt
  );

  modport slave (
    input  d,
    output qout,
    output valid,
    output fill_cnt
  );
endinterface

// File: rtl/siso_shift_register.sv
// Serial-in serial-out delay line of DEPTH flops with a saturating fill counter.
// valid marks the point where qout first carries a post-reset bit instead of reset zeros.
module siso_shift_register #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  siso_shift_register_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("siso_shift_register: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;
  logic [CNT_W-1:0] fill_cnt_q;
  logic [CNT_W-1:0] fill_cnt_d;
  logic             valid_q;
  logic             valid_d;

  // A single-stage line has no older bits to shift, so it just recaptures d.
  if (DEPTH == 1) begin : g_single
    always_comb begin
      sr_d = bus.d;
    end
  end else begin : g_chain
    always_comb begin
      sr_d = {sr_q[DEPTH-2:0], bus.d};
    end
  end

  // valid is derived from the next count so it rises on the same edge as the count hits DEPTH.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (fill_cnt_q != CNT_W'(DEPTH)) begin
      fill_cnt_d = fill_cnt_q + CNT_W'(1);
    end
    valid_d = (fill_cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q       <= '0;
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.qout     = sr_q[DEPTH-1];
  assign bus.valid    = valid_q;
  assign bus.fill_cnt = fill_cnt_q;

endmodule

// File: tb/tb_siso_shift_register.sv
// Scoreboard bench for siso_shift_register: a driver pushes model predictions per edge,
// a monitor pops and compares them after every rising clock.
module tb_siso_shift_register;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct {
    logic             q;
    logic             v;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   passes;
  exp_t exp_q[$];
  logic hist[$];

  siso_shift_register_if #(.DEPTH(DEPTH)) bus ();

  siso_shift_register #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end else begin
      passes++;
    end
  endtask

  // Model: the bit on qout after k edges since reset is the one sampled at edge k-DEPTH+1.
  task automatic drive_bit(input logic b);
    exp_t e;
    int   k;
    @(negedge clk);
    reset  = 1'b1;
    bus.d  = b;
    hist.push_back(b);
    k      = hist.size();
    e.q    = (k >= DEPTH) ? hist[k-DEPTH] : 1'b0;
    e.v    = (k >= DEPTH);
    e.cnt  = (k >= DEPTH) ? CNT_W'(DEPTH) : CNT_W'(k);
    exp_q.push_back(e);
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic pulse_reset(input int low_cycles);
    exp_t z;
    z.q   = 1'b0;
    z.v   = 1'b0;
    z.cnt = '0;
    @(negedge clk);
    bus.d = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_qout", {7'b0, bus.qout}, 8'd0);
    check("async_valid", {7'b0, bus.valid}, 8'd0);
    check("async_fill", 8'(bus.fill_cnt), 8'd0);
    hist.delete();
    exp_q.push_back(z);
    for (int i = 1; i < low_cycles; i++) begin
      @(negedge clk);
      exp_q.push_back(z);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("qout", {7'b0, bus.qout}, {7'b0, e.q});
        check("valid", {7'b0, bus.valid}, {7'b0, e.v});
        check("fill_cnt", 8'(bus.fill_cnt), 8'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    logic pat[8];
    checks = 0;
    passes = 0;
    reset  = 1'b0;
    bus.d  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_qout", {7'b0, bus.qout}, 8'd0);
    check("reset_valid", {7'b0, bus.valid}, 8'd0);
    check("reset_fill", 8'(bus.fill_cnt), 8'd0);

    // Fill every stage with 1s, then drop reset mid-cycle.
    repeat (5) drive_bit(1'b1);
    pulse_reset(2);

    // Single 1 followed by zeros must appear for exactly one cycle.
    drive_bit(1'b1);
    repeat (7) drive_bit(1'b0);
    pulse_reset(1);

    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    foreach (pat[i]) drive_bit(pat[i]);
    repeat (DEPTH) drive_bit(1'b0);
    pulse_reset(1);

    // Reset pulse after two captured 1s discards them.
    drive_bit(1'b1);
    drive_bit(1'b1);
    pulse_reset(1);
    repeat (6) drive_bit(1'b0);

    repeat (10) drive_bit(1'b1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulse_reset(int'($urandom_range(1, 2)));
      end
      drive_bit(1'($urandom));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    check("drain", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
